quadrature_step_decoder: RTL and testbench

QUADRATURE_STEP_DECODER -- requirements
Module: quadrature_step_decoder

---
 rtl/quadrature_step_decoder.sv | 134 +++++++++++++
 tb/tb_quadrature_step_decoder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/quadrature_step_decoder.sv
// Quadrature encoder decoder: synchronizes and debounces A/B,
// accumulates legal transitions into steps and a wrapping position.
module quadrature_step_decoder #(
    parameter int FILTER_CYCLES  = 4,
    parameter int EDGES_PER_STEP = 4,
    parameter int COUNT_WIDTH    = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   enc_A,
    input  logic                   enc_B,
    input  logic                   pos_clear,
    output logic                   step_pulse,
    output logic                   step_dir,
    output logic [COUNT_WIDTH-1:0] position,
    output logic                   seq_err
);

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

    localparam logic [3:0] FILT_LAST = 4'(FILTER_CYCLES - 1);
    localparam logic signed [3:0] EDGE_POS = 4'(EDGES_PER_STEP);
    localparam logic signed [3:0] EDGE_NEG = -EDGE_POS;
    localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

    state_t state, state_next;

    // Bit 1 carries channel A, bit 0 channel B throughout.
    logic [1:0] sync1, sync2, filt, prev;
    logic [3:0] cnt [2];
    logic [3:0] stab_cnt;
    logic signed [3:0] acc, acc_sum, delta;
    logic stable, bad, step_fwd, step_rev, active;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {enc_A, enc_B};
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != filt[i]) begin
                    if (cnt[i] == FILT_LAST) begin
                        filt[i] <= sync2[i];
                        cnt[i]  <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 4'd1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // Baseline is only trusted once raw, synchronized and filtered levels agree.
    assign stable = (sync1 == sync2) && (sync2 == filt);
    assign active = (state == RUN) && en;

    always_comb begin
        state_next = state;
        delta      = '0;
        bad        = 1'b0;
        case (state)
            INIT: if (stable && stab_cnt == FILT_LAST) state_next = RUN;
            RUN:  state_next = RUN;
            default: state_next = INIT;
        endcase
        case ({prev, filt})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: delta = 4'sd1;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: delta = -4'sd1;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: bad = 1'b1;
            default: delta = '0;
        endcase
        acc_sum  = acc + delta;
        step_fwd = active && !bad && (acc_sum == EDGE_POS);
        step_rev = active && !bad && (acc_sum == EDGE_NEG);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= INIT;
            stab_cnt <= '0;
            prev     <= '0;
        end else begin
            state <= state_next;
            prev  <= filt;
            if (state == INIT && stable) stab_cnt <= stab_cnt + 4'd1;
            else stab_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_pulse <= 1'b0;
            step_dir   <= 1'b0;
            seq_err    <= 1'b0;
            position   <= '0;
            acc        <= '0;
        end else begin
            step_pulse <= 1'b0;
            seq_err    <= active && bad;
            if (pos_clear) begin
                position <= '0;
                acc      <= '0;
            end else if (!active || bad) begin
                acc <= '0;
            end else if (step_fwd) begin
                step_pulse <= 1'b1;
                step_dir   <= 1'b1;
                position   <= position + ONE;
                acc        <= '0;
            end else if (step_rev) begin
                step_pulse <= 1'b1;
                step_dir   <= 1'b0;
                position   <= position - ONE;
                acc        <= '0;
            end else begin
                acc <= acc_sum;
            end
        end
    end

endmodule

// File: tb/tb_quadrature_step_decoder.sv
// Directed bench for quadrature_step_decoder with default parameters.
module tb_quadrature_step_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b1;
    logic       enc_A = 1'b1;
    logic       enc_B = 1'b1;
    logic       pos_clear = 1'b0;
    logic       step_pulse;
    logic       step_dir;
    logic [6:0] position;
    logic       seq_err;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int n_steps = 0;
    int n_errs = 0;
    int last_pulse_cyc = 0;
    int s0, e0, c0;

    quadrature_step_decoder dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .enc_A(enc_A),
        .enc_B(enc_B),
        .pos_clear(pos_clear),
        .step_pulse(step_pulse),
        .step_dir(step_dir),
        .position(position),
        .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (step_pulse) begin
            n_steps++;
            last_pulse_cyc = cyc;
        end
        if (seq_err) n_errs++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply(input logic [1:0] ab, input int n);
        {enc_A, enc_B} = ab;
        tick(n);
    endtask

    task automatic snap();
        s0 = n_steps;
        e0 = n_errs;
    endtask

    // Forward cycle starting from level 10, ending at 10.
    task automatic fwd_from10();
        apply(2'b00, 10);
        apply(2'b01, 10);
        apply(2'b11, 10);
        apply(2'b10, 10);
    endtask

    initial begin
        // Reset with A=B=1 held
        tick(3);
        chk("rst_pulse", int'(step_pulse), 0);
        chk("rst_pos", int'(position), 0);
        chk("rst_dir", int'(step_dir), 0);
        chk("rst_err", int'(seq_err), 0);
        snap();
        reset = 1'b0;
        tick(20);
        chk("init11_steps", n_steps - s0, 0);
        chk("init11_errs", n_errs - e0, 0);
        chk("init11_run", int'(dut.state), 1);
        chk("init11_pos", int'(position), 0);

        // Re-baseline at 00, then one forward cycle
        reset = 1'b1;
        {enc_A, enc_B} = 2'b00;
        tick(3);
        reset = 1'b0;
        tick(20);
        snap();
        apply(2'b01, 10);
        apply(2'b11, 10);
        apply(2'b10, 10);
        {enc_A, enc_B} = 2'b00;
        c0 = cyc;
        tick(20);
        chk("fwd_steps", n_steps - s0, 1);
        chk("fwd_dir", int'(step_dir), 1);
        chk("fwd_pos", int'(position), 1);
        chk("fwd_latency", last_pulse_cyc - c0, 7);
        chk("fwd_errs", n_errs - e0, 0);

        // Clear, then one reverse cycle wraps to 127
        pos_clear = 1'b1;
        tick(1);
        pos_clear = 1'b0;
        tick(1);
        chk("clr_pos", int'(position), 0);
        snap();
        apply(2'b10, 10);
        apply(2'b11, 10);
        apply(2'b01, 10);
        apply(2'b00, 20);
        chk("rev_steps", n_steps - s0, 1);
        chk("rev_dir", int'(step_dir), 0);
        chk("rev_pos", int'(position), 127);

        // 3-cycle glitch on A is rejected
        snap();
        enc_A = 1'b1;
        tick(3);
        enc_A = 1'b0;
        tick(20);
        chk("glitch_filt", int'(dut.filt), 0);
        chk("glitch_steps", n_steps - s0, 0);
        chk("glitch_errs", n_errs - e0, 0);
        chk("glitch_pos", int'(position), 127);

        // 00 -> 01 (partial), then 01 -> 10 illegal
        snap();
        apply(2'b01, 10);
        chk("partial_acc", int'(dut.acc), 1);
        apply(2'b10, 20);
        chk("err_count", n_errs - e0, 1);
        chk("err_acc", int'(dut.acc), 0);
        chk("err_steps", n_steps - s0, 0);
        chk("err_pos", int'(position), 127);

        // Both bits toggling together 10 -> 01
        snap();
        apply(2'b01, 20);
        chk("err2_count", n_errs - e0, 1);
        chk("err2_pos", int'(position), 127);
        apply(2'b10, 20);

        // Reach position 5 with forward cycles
        pos_clear = 1'b1;
        tick(1);
        pos_clear = 1'b0;
        snap();
        for (int i = 0; i < 5; i++) fwd_from10();
        chk("five_pos", int'(position), 5);
        chk("five_steps", n_steps - s0, 5);

        // pos_clear coincident with step completion
        snap();
        apply(2'b00, 10);
        apply(2'b01, 10);
        apply(2'b11, 10);
        {enc_A, enc_B} = 2'b10;
        tick(6);
        pos_clear = 1'b1;
        tick(1);
        pos_clear = 1'b0;
        tick(10);
        chk("clrwin_pos", int'(position), 0);
        chk("clrwin_steps", n_steps - s0, 0);
        chk("clrwin_dir", int'(step_dir), 1);

        // Disabled full cycle leaves position alone
        snap();
        en = 1'b0;
        fwd_from10();
        tick(10);
        chk("en0_pos", int'(position), 0);
        chk("en0_steps", n_steps - s0, 0);
        chk("en0_errs", n_errs - e0, 0);
        en = 1'b1;
        tick(2);
        snap();
        fwd_from10();
        tick(10);
        chk("en1_pos", int'(position), 1);
        chk("en1_steps", n_steps - s0, 1);

        // Reset mid-step discards partial progress
        apply(2'b00, 10);
        apply(2'b01, 10);
        reset = 1'b1;
        tick(3);
        chk("midrst_pos", int'(position), 0);
        reset = 1'b0;
        snap();
        tick(20);
        apply(2'b11, 10);
        apply(2'b10, 20);
        chk("midrst_steps", n_steps - s0, 0);
        chk("midrst_errs", n_errs - e0, 0);
        chk("midrst_pos2", int'(position), 0);
        chk("midrst_acc", int'(dut.acc), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
